// File: rtl/iscore_pkg.sv
// rtl/iscore_pkg.sv - shared pixel-type constants, RGB width and coordinate typedef
package iscore_pkg;

    localparam logic [1:0] PT_NOTE   = 2'b00;
    localparam logic [1:0] PT_STAFF  = 2'b01;
    localparam logic [1:0] PT_CURSOR = 2'b10;
    localparam logic [1:0] PT_BG     = 2'b11;

    localparam int RGB_W = 24;

    typedef struct packed {
        logic [9:0] y;
        logic [9:0] x;
    } coord_t;

    // The overlay never renders notes, so a NOTE code from it is painted as background.
    function automatic logic [1:0] ovl_ptype_legal(input logic [1:0] ptype);
        return (ptype == PT_NOTE) ? PT_BG : ptype;
    endfunction

endpackage

// File: rtl/color.sv
// rtl/color.sv - combinational pixel/instrument type to RGB lookup
module color
    import iscore_pkg::*;
(
    input  logic [1:0]       pixel_type,
    input  logic [1:0]       instrument_type,
    output logic [RGB_W-1:0] rgb
);

    // Notes are colored per instrument; staff and cursor are white; background is black.
    always_comb begin
        rgb = '0;
        case (pixel_type)
            PT_NOTE: begin
                case (instrument_type)
                    2'd0:    rgb = 24'hFF0000;
                    2'd1:    rgb = 24'h00FF00;
                    2'd2:    rgb = 24'h0000FF;
                    default: rgb = 24'hFFFFFF;
                endcase
            end
            PT_STAFF, PT_CURSOR: rgb = 24'hFFFFFF;
            default:             rgb = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin grant with pointer advance on use
module rr_arbiter #(
    parameter int N = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] rr_ptr;
    logic             found;
    int               idx;

    // First requester at or after rr_ptr, scanning with wrap-around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

    // Move the pointer just past the requester that was actually served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            if (grant_idx == IDX_W'(N - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_req_scheduler.sv
// rtl/pixel_req_scheduler.sv - arbitrates instrument/overlay pixel requests into a 2-stage color pipeline
module pixel_req_scheduler
    import iscore_pkg::*;
#(
    parameter int N_INST     = 3,
    parameter int COORD_W    = 20,
    parameter int STARVE_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_INST-1:0]         inst_valid,
    input  logic [N_INST*COORD_W-1:0] inst_coord,
    output logic [N_INST-1:0]         inst_ready,
    input  logic                      ovl_valid,
    input  logic [1:0]                ovl_ptype,
    input  logic [COORD_W-1:0]        ovl_coord,
    output logic                      ovl_ready,
    output logic                      out_valid,
    output logic [RGB_W-1:0]          out_rgb,
    output logic [COORD_W-1:0]        out_coord,
    input  logic                      out_ready
);

    localparam int IDX_W = (N_INST > 1) ? $clog2(N_INST) : 1;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    // Stage A: granted request waiting for its color lookup.
    logic               a_valid;
    logic [1:0]         a_ptype;
    logic [1:0]         a_itype;
    logic [COORD_W-1:0] a_coord;

    // Stage B: finished pixel presented downstream.
    logic               b_valid;
    logic [RGB_W-1:0]   b_rgb;
    logic [COORD_W-1:0] b_coord;

    logic [CNT_W-1:0]   starve_cnt;

    logic               b_load;
    logic               a_load;
    logic               any_inst;
    logic               force_inst;
    logic               grant_inst;
    logic               grant_ovl;
    logic [N_INST-1:0]  arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic [COORD_W-1:0] grant_coord;
    logic [1:0]         color_ptype;
    logic [1:0]         color_itype;
    logic [RGB_W-1:0]   color_rgb;

    assign b_load   = !b_valid || out_ready;
    assign a_load   = !a_valid || b_load;
    assign any_inst = |inst_valid;

    // Once the overlay has won STARVE_MAX times in a row, a waiting instrument goes first.
    assign force_inst = (starve_cnt == CNT_W'(STARVE_MAX)) && any_inst;
    assign grant_inst = rst_n && a_load && any_inst && (force_inst || !ovl_valid);
    assign grant_ovl  = rst_n && a_load && ovl_valid && !force_inst;

    assign inst_ready = grant_inst ? arb_grant : '0;
    assign ovl_ready  = grant_ovl;

    rr_arbiter #(
        .N(N_INST)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (inst_valid),
        .advance   (grant_inst),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Pick the coordinate slice of whichever instrument the arbiter selected.
    always_comb begin
        grant_coord = '0;
        for (int i = 0; i < N_INST; i++) begin
            if (arb_grant[i]) begin
                grant_coord = inst_coord[i*COORD_W +: COORD_W];
            end
        end
    end

    // An empty stage A presents background so the lookup output is well defined.
    always_comb begin
        color_ptype = a_valid ? a_ptype : PT_BG;
        color_itype = a_valid ? a_itype : 2'd0;
    end

    color u_color (
        .pixel_type      (color_ptype),
        .instrument_type (color_itype),
        .rgb             (color_rgb)
    );

    // Stage A captures the granted request whenever it is free or draining into B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_ptype <= PT_BG;
            a_itype <= '0;
            a_coord <= '0;
        end else if (a_load) begin
            a_valid <= grant_inst || grant_ovl;
            if (grant_inst) begin
                a_ptype <= PT_NOTE;
                a_itype <= 2'(arb_idx);
                a_coord <= grant_coord;
            end else if (grant_ovl) begin
                a_ptype <= ovl_ptype_legal(ovl_ptype);
                a_itype <= '0;
                a_coord <= ovl_coord;
            end
        end
    end

    // Stage B registers the looked-up color; data only changes when a real pixel arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            b_rgb   <= '0;
            b_coord <= '0;
        end else if (b_load) begin
            b_valid <= a_valid;
            if (a_valid) begin
                b_rgb   <= color_rgb;
                b_coord <= a_coord;
            end
        end
    end

    // Count consecutive overlay wins that happened while an instrument was waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_inst || !any_inst) begin
            starve_cnt <= '0;
        end else if (grant_ovl) begin
            if (starve_cnt != CNT_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = b_valid;
    assign out_rgb   = b_rgb;
    assign out_coord = b_coord;

endmodule

// File: tb/tb_pixel_req_scheduler.sv
// tb/tb_pixel_req_scheduler.sv - self-checking bench for pixel_req_scheduler
module tb_pixel_req_scheduler;

    localparam int N_INST     = 3;
    localparam int COORD_W    = 20;
    localparam int STARVE_MAX = 4;
    localparam int OVL_ID     = N_INST;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [N_INST-1:0]         inst_valid;
    logic [N_INST*COORD_W-1:0] inst_coord;
    logic [N_INST-1:0]         inst_ready;
    logic                      ovl_valid;
    logic [1:0]                ovl_ptype;
    logic [COORD_W-1:0]        ovl_coord;
    logic                      ovl_ready;
    logic                      out_valid;
    logic [23:0]               out_rgb;
    logic [COORD_W-1:0]        out_coord;
    logic                      out_ready;

    always #5 clk = ~clk;

    pixel_req_scheduler #(
        .N_INST(N_INST), .COORD_W(COORD_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid(inst_valid), .inst_coord(inst_coord), .inst_ready(inst_ready),
        .ovl_valid(ovl_valid), .ovl_ptype(ovl_ptype), .ovl_coord(ovl_coord), .ovl_ready(ovl_ready),
        .out_valid(out_valid), .out_rgb(out_rgb), .out_coord(out_coord), .out_ready(out_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Requester behaviour: each holds a request until it is accepted, then moves on.
    int               inst_left [N_INST];
    int               inst_seq  [N_INST];
    logic [COORD_W-1:0] inst_base [N_INST];
    int               ovl_left;
    int               ovl_seq;
    logic [COORD_W-1:0] ovl_base;
    logic [1:0]       ovl_pt;

    // Model: in-flight pixels (at most two), fairness pointer and starvation count.
    typedef struct {
        logic [23:0]        rgb;
        logic [COORD_W-1:0] coord;
        bit                 at_out;
    } item_t;
    item_t pipe[$];
    int    rr;
    int    starve;

    int                 grant_log[$];
    int                 grant_cyc_log[$];
    logic [23:0]        out_rgb_log[$];
    logic [COORD_W-1:0] out_coord_log[$];
    int                 out_cyc_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [23:0] rgb_of_inst(input int i);
        logic [23:0] tbl [3] = '{24'hFF0000, 24'h00FF00, 24'h0000FF};
        return tbl[i];
    endfunction

    function automatic logic [23:0] rgb_of_ovl(input logic [1:0] pt);
        return (pt == 2'b01 || pt == 2'b10) ? 24'hFFFFFF : 24'h000000;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N_INST; i++) begin
            inst_valid[i] = (inst_left[i] > 0);
            inst_coord[i*COORD_W +: COORD_W] = inst_base[i] + COORD_W'(inst_seq[i]);
        end
        ovl_valid = (ovl_left > 0);
        ovl_ptype = ovl_pt;
        ovl_coord = ovl_base + COORD_W'(ovl_seq);
    endtask

    task automatic clear_state();
        for (int i = 0; i < N_INST; i++) begin
            inst_left[i] = 0;
            inst_seq[i]  = 0;
            inst_base[i] = '0;
        end
        ovl_left = 0;
        ovl_seq  = 0;
        ovl_base = '0;
        ovl_pt   = 2'b01;
        pipe.delete();
        rr     = 0;
        starve = 0;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        grant_cyc_log.delete();
        out_rgb_log.delete();
        out_coord_log.delete();
        out_cyc_log.delete();
        cyc = 0;
    endtask

    // One clock: drive, predict and compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int                eg;
        int                j;
        bit                any;
        bit                has_out;
        bit                has_pend;
        bit                can_acc;
        logic [N_INST-1:0] want_ir;
        item_t             it;
        drive_inputs();
        @(negedge clk);
        any = 1'b0;
        for (int i = 0; i < N_INST; i++) begin
            if (inst_left[i] > 0) any = 1'b1;
        end
        has_out  = (pipe.size() > 0) && pipe[0].at_out;
        has_pend = (pipe.size() > (has_out ? 1 : 0));
        can_acc  = !has_pend || !has_out || out_ready;
        eg = -1;
        if (can_acc) begin
            if (any && ((starve == STARVE_MAX) || ovl_left == 0)) begin
                for (int k = 0; k < N_INST; k++) begin
                    j = (rr + k) % N_INST;
                    if (eg < 0 && inst_left[j] > 0) eg = j;
                end
            end else if (ovl_left > 0) begin
                eg = OVL_ID;
            end
        end
        want_ir = '0;
        if (eg >= 0 && eg < N_INST) want_ir[eg] = 1'b1;
        chk("inst_ready", 32'(inst_ready), 32'(want_ir));
        chk("ovl_ready", 32'(ovl_ready), 32'(eg == OVL_ID));
        chk("out_valid", 32'(out_valid), 32'(has_out));
        if (has_out) begin
            chk("out_rgb", 32'(out_rgb), 32'(pipe[0].rgb));
            chk("out_coord", 32'(out_coord), 32'(pipe[0].coord));
        end
        @(posedge clk);
        if (!has_out || out_ready) begin
            if (has_out) begin
                out_rgb_log.push_back(pipe[0].rgb);
                out_coord_log.push_back(pipe[0].coord);
                out_cyc_log.push_back(cyc);
                void'(pipe.pop_front());
            end
            if (pipe.size() > 0) begin
                it = pipe[0];
                it.at_out = 1'b1;
                pipe[0] = it;
            end
        end
        if (eg >= 0) begin
            grant_log.push_back(eg);
            grant_cyc_log.push_back(cyc);
            it.at_out = 1'b0;
            if (eg < N_INST) begin
                it.rgb   = rgb_of_inst(eg);
                it.coord = inst_base[eg] + COORD_W'(inst_seq[eg]);
                inst_left[eg]--;
                inst_seq[eg]++;
                rr = (eg + 1) % N_INST;
            end else begin
                it.rgb   = rgb_of_ovl(ovl_pt);
                it.coord = ovl_base + COORD_W'(ovl_seq);
                ovl_left--;
                ovl_seq++;
            end
            pipe.push_back(it);
        end
        if (!any || (eg >= 0 && eg < N_INST)) begin
            starve = 0;
        end else if (eg == OVL_ID && starve < STARVE_MAX) begin
            starve++;
        end
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_state();
        drive_inputs();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
    endtask

    function automatic int g_at(input int k);
        return (grant_log.size() > k) ? grant_log[k] : -1;
    endfunction

    function automatic logic [23:0] rgb_at(input int k);
        return (out_rgb_log.size() > k) ? out_rgb_log[k] : 24'hDEAD00;
    endfunction

    function automatic logic [COORD_W-1:0] coord_at(input int k);
        return (out_coord_log.size() > k) ? out_coord_log[k] : '1;
    endfunction

    initial begin
        int          g3   [10] = '{3, 3, 3, 3, 0, 3, 3, 3, 3, 0};
        logic [23:0] r3   [10] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFF0000,
                                   24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFF0000};
        int          g2   [4]  = '{0, 1, 2, 0};
        logic [23:0] r2   [4]  = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF0000};
        logic [19:0] c4   [6]  = '{20'h20000, 20'h30000, 20'h20001, 20'h30001, 20'h20002, 20'h30002};

        // Reset state, with every requester asserting valid.
        out_ready  = 1'b1;
        inst_valid = '1;
        inst_coord = '0;
        ovl_valid  = 1'b1;
        ovl_ptype  = 2'b01;
        ovl_coord  = '0;
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_rgb", 32'(out_rgb), 32'h0);
        chk("reset_out_coord", 32'(out_coord), 32'h0);
        chk("reset_inst_ready", 32'(inst_ready), 32'h0);
        chk("reset_ovl_ready", 32'(ovl_ready), 32'h0);

        // Single instrument-1 request.
        do_reset();
        inst_base[1] = 20'h00A05;
        inst_left[1] = 1;
        run(6);
        chk("t1_grants", grant_log.size(), 1);
        chk("t1_grant", g_at(0), 1);
        chk("t1_outs", out_rgb_log.size(), 1);
        chk("t1_rgb", 32'(rgb_at(0)), 32'h00FF00);
        chk("t1_coord", 32'(coord_at(0)), 32'h00A05);
        if (out_cyc_log.size() > 0 && grant_cyc_log.size() > 0)
            chk("t1_latency", out_cyc_log[0] - grant_cyc_log[0], 2);
        else
            chk("t1_latency_present", 0, 1);

        // All instruments busy, no overlay: plain rotation.
        do_reset();
        for (int i = 0; i < N_INST; i++) begin
            inst_base[i] = COORD_W'(32'h01000 + i * 32'h100);
            inst_left[i] = 4;
        end
        run(18);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_grant%0d", k), g_at(k), g2[k]);
            chk($sformatf("t2_rgb%0d", k), 32'(rgb_at(k)), 32'(r2[k]));
        end
        chk("t2_outs", out_rgb_log.size(), 12);

        // Overlay (staff) against one instrument: starvation guard.
        do_reset();
        ovl_pt       = 2'b01;
        ovl_base     = 20'h40000;
        ovl_left     = 8;
        inst_base[0] = 20'h50000;
        inst_left[0] = 2;
        run(16);
        chk("t3_grants", grant_log.size(), 10);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t3_grant%0d", k), g_at(k), g3[k]);
            chk($sformatf("t3_rgb%0d", k), 32'(rgb_at(k)), 32'(r3[k]));
        end

        // Six pixels with a five-cycle downstream stall in the middle.
        do_reset();
        inst_base[0] = 20'h20000;
        inst_base[2] = 20'h30000;
        inst_left[0] = 3;
        inst_left[2] = 3;
        run(3);
        out_ready = 1'b0;
        run(5);
        out_ready = 1'b1;
        run(10);
        chk("t4_outs", out_coord_log.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t4_coord%0d", k), 32'(coord_at(k)), 32'(c4[k]));
        end

        // Overlay NOTE (illegal) and BG both render black.
        do_reset();
        ovl_base = 20'h05005;
        ovl_pt   = 2'b00;
        ovl_left = 1;
        run(4);
        ovl_pt   = 2'b11;
        ovl_left = 1;
        run(4);
        chk("t5_outs", out_rgb_log.size(), 2);
        chk("t5_rgb_note", 32'(rgb_at(0)), 32'h000000);
        chk("t5_rgb_bg", 32'(rgb_at(1)), 32'h000000);
        chk("t5_coord_bg", 32'(coord_at(1)), 32'h05006);

        // Asynchronous reset with both stages full.
        do_reset();
        for (int i = 0; i < N_INST; i++) begin
            inst_base[i] = COORD_W'(32'h60000 + i * 32'h10);
            inst_left[i] = 5;
        end
        run(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_out_valid", 32'(out_valid), 32'h0);
        chk("t6_async_inst_ready", 32'(inst_ready), 32'h0);
        clear_state();
        drive_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        for (int i = 0; i < N_INST; i++) begin
            inst_base[i] = COORD_W'(32'h70000 + i * 32'h10);
            inst_left[i] = 1;
        end
        run(8);
        chk("t6_first_grant", g_at(0), 0);
        chk("t6_outs", out_coord_log.size(), 3);
        chk("t6_first_coord", 32'(coord_at(0)), 32'h70000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
